// File: rtl/multicycle_controller_if.sv
// Bundle of control-path signals between the multicycle controller and the
// datapath. master = controller side, slave = datapath side.
interface multicycle_controller_if;
  logic [6:0] Op;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] ImmSrc;
  logic       RegWrite;
  logic       Halted;

  modport master (
    input  Op, Zero, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUOp, ImmSrc, RegWrite, Halted
  );

  modport slave (
    output Op, Zero, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUOp, ImmSrc, RegWrite, Halted
  );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core.
// Sequences fetch/decode/execute/memory/writeback, stalls on MemReady in the
// memory-access states and drives the datapath selects and write strobes.
// Optional feature: define CTRL_PERF_CNT_EN to add the InstrRetired and
// StallCycles performance counters (PERF_W bits wide).
module multicycle_controller #(
  parameter bit ILLEGAL_HALT = 1'b1
`ifdef CTRL_PERF_CNT_EN
  , parameter int PERF_W = 32
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.master bus
`ifdef CTRL_PERF_CNT_EN
  , output logic [PERF_W-1:0]    InstrRetired
  , output logic [PERF_W-1:0]    StallCycles
`endif
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_BEQ      = 4'd10;
  localparam logic [3:0] S_HALT     = 4'd11;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  logic [3:0] state_q, state_d;
  logic       pc_update, branch, ir_write, mem_write, reg_write, adr_src, halted;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;

  // Next-state selection and Moore decode of the datapath controls.
  always_comb begin
    state_d    = state_q;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    adr_src    = 1'b0;
    halted     = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = bus.MemReady;
        pc_update  = bus.MemReady;
        if (bus.MemReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (bus.Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = ILLEGAL_HALT ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = bus.Op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (bus.MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (bus.MemReady) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT: begin
        halted  = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Immediate format depends only on the opcode currently in the IR.
  always_comb begin
    case (bus.Op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign bus.PCWrite   = ~reset & (pc_update | (branch & bus.Zero));
  assign bus.IRWrite   = ~reset & ir_write;
  assign bus.MemWrite  = ~reset & mem_write;
  assign bus.RegWrite  = ~reset & reg_write;
  assign bus.AdrSrc    = adr_src;
  assign bus.ResultSrc = result_src;
  assign bus.ALUSrcA   = alu_src_a;
  assign bus.ALUSrcB   = alu_src_b;
  assign bus.ALUOp     = alu_op;
  assign bus.ImmSrc    = imm_src;
  assign bus.Halted    = halted;

`ifdef CTRL_PERF_CNT_EN
  logic [PERF_W-1:0] instr_retired_q, instr_retired_d;
  logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;
  logic              retire_now, stall_now;

  // An instruction retires whenever the FSM re-enters FETCH; a stall is any
  // cycle spent waiting on the memory in a MemReady-sensitive state.
  always_comb begin
    retire_now = (state_q != S_FETCH) && (state_d == S_FETCH);
    stall_now  = ~bus.MemReady &&
                 ((state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE));
    instr_retired_d = instr_retired_q + {{(PERF_W-1){1'b0}}, retire_now};
    stall_cycles_d  = stall_cycles_q + {{(PERF_W-1){1'b0}}, stall_now};
  end

  // Counter registers, cleared by reset and wrapping naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_retired_q <= '0;
      stall_cycles_q  <= '0;
    end else begin
      instr_retired_q <= instr_retired_d;
      stall_cycles_q  <= stall_cycles_d;
    end
  end

  assign InstrRetired = instr_retired_q;
  assign StallCycles  = stall_cycles_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. Expected outputs come from an
// instruction-level schedule: each instruction is expanded into its list of
// cycles (fetch waits, decode, class-specific phases, memory waits).
module tb_multicycle_controller;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  typedef struct {
    logic [6:0]  op;
    logic        zero;
    logic        memReady;
    logic        rst;
    logic [15:0] expOut;
    bit          retire;
    bit          stall;
    string       tag;
  } step_t;

  logic clk = 1'b0;
  logic reset;
  int   nVectors = 0;
  int   nMiscompares = 0;
  int   expInstr = 0;
  int   expStall = 0;
  step_t stepQ[$];

  always #5 clk = ~clk;

  multicycle_controller_if bus();

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] instrRetired, stallCycles;
  multicycle_controller #(.ILLEGAL_HALT(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .InstrRetired(instrRetired), .StallCycles(stallCycles)
  );
`else
  multicycle_controller #(.ILLEGAL_HALT(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
`endif

  function automatic logic [1:0] immFor(input logic [6:0] op);
    case (op)
      OP_SW:   return 2'b01;
      OP_BEQ:  return 2'b10;
      OP_JAL:  return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // {Halted, PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc}
  function automatic logic [15:0] outWord(input logic halted, input logic pcw, input logic regw,
                                          input logic memw, input logic irw, input logic adr,
                                          input logic [1:0] res, input logic [1:0] sa,
                                          input logic [1:0] sb, input logic [1:0] aop,
                                          input logic [1:0] imm);
    return {halted, pcw, regw, memw, irw, adr, res, sa, sb, aop, imm};
  endfunction

  function automatic logic rndBit();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic pushStep(input logic [6:0] op, input logic zero, input logic mr, input logic rst,
                          input logic [15:0] out, input bit retire, input bit stall, input string tag);
    step_t s;
    s.op = op; s.zero = zero; s.memReady = mr; s.rst = rst;
    s.expOut = out; s.retire = retire; s.stall = stall; s.tag = tag;
    stepQ.push_back(s);
  endtask

  // Expand one instruction into its expected cycle sequence.
  task automatic buildInstr(input logic [6:0] op, input int fetchWait, input int memWait,
                            input logic zeroBit);
    logic [1:0] imm;
    imm = immFor(op);
    for (int i = 0; i < fetchWait; i++)
      pushStep(op, rndBit(), 1'b0, 1'b0, outWord(0,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,imm), 0, 1, "fetchWait");
    pushStep(op, rndBit(), 1'b1, 1'b0, outWord(0,1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,imm), 0, 0, "fetch");
    pushStep(op, rndBit(), rndBit(), 1'b0, outWord(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,imm), 0, 0, "decode");
    case (op)
      OP_LW: begin
        pushStep(op, rndBit(), rndBit(), 1'b0, outWord(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,imm), 0, 0, "lwAddr");
        for (int i = 0; i < memWait; i++)
          pushStep(op, rndBit(), 1'b0, 1'b0, outWord(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,imm), 0, 1, "lwWait");
        pushStep(op, rndBit(), 1'b1, 1'b0, outWord(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,imm), 0, 0, "lwRead");
        pushStep(op, rndBit(), rndBit(), 1'b0, outWord(0,0,1,0,0,0,2'b01,2'b00,2'b00,2'b00,imm), 1, 0, "lwWb");
      end
      OP_SW: begin
        pushStep(op, rndBit(), rndBit(), 1'b0, outWord(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,imm), 0, 0, "swAddr");
        for (int i = 0; i < memWait; i++)
          pushStep(op, rndBit(), 1'b0, 1'b0, outWord(0,0,0,1,0,1,2'b00,2'b00,2'b00,2'b00,imm), 0, 1, "swWait");
        pushStep(op, rndBit(), 1'b1, 1'b0, outWord(0,0,0,1,0,1,2'b00,2'b00,2'b00,2'b00,imm), 1, 0, "swWrite");
      end
      OP_R, OP_I: begin
        pushStep(op, rndBit(), rndBit(), 1'b0,
                 outWord(0,0,0,0,0,0,2'b00,2'b10,(op == OP_I) ? 2'b01 : 2'b00,2'b10,imm), 0, 0, "exec");
        pushStep(op, rndBit(), rndBit(), 1'b0, outWord(0,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,imm), 1, 0, "aluWb");
      end
      OP_JAL: begin
        pushStep(op, rndBit(), rndBit(), 1'b0, outWord(0,1,0,0,0,0,2'b00,2'b01,2'b10,2'b00,imm), 0, 0, "jal");
        pushStep(op, rndBit(), rndBit(), 1'b0, outWord(0,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,imm), 1, 0, "jalWb");
      end
      OP_BEQ: begin
        pushStep(op, zeroBit, rndBit(), 1'b0, outWord(0,zeroBit,0,0,0,0,2'b00,2'b10,2'b00,2'b01,imm), 1, 0, "beq");
      end
      default: begin
        for (int i = 0; i < 20; i++)
          pushStep(op, rndBit(), rndBit(), 1'b0, outWord(1,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,imm), 0, 0, "halt");
      end
    endcase
  endtask

  // Drive one cycle's inputs (called at the falling edge).
  task automatic applyStimulus(input step_t s);
    reset        = s.rst;
    bus.Op       = s.op;
    bus.Zero     = s.zero;
    bus.MemReady = s.memReady;
  endtask

  // Compare the DUT outputs of the current cycle against the schedule.
  task automatic checkOutput(input step_t s);
    logic [15:0] obs;
    #1;
    obs = {bus.Halted, bus.PCWrite, bus.RegWrite, bus.MemWrite, bus.IRWrite, bus.AdrSrc,
           bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.ImmSrc};
    nVectors++;
    assert (obs === s.expOut) else begin
      nMiscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", s.tag, obs, s.expOut);
    end
`ifdef CTRL_PERF_CNT_EN
    nVectors++;
    assert (instrRetired === 32'(expInstr)) else begin
      nMiscompares++;
      $error("[TB] FAIL instrRetired@%s: observed %0d expected %0d", s.tag, instrRetired, expInstr);
    end
    nVectors++;
    assert (stallCycles === 32'(expStall)) else begin
      nMiscompares++;
      $error("[TB] FAIL stallCycles@%s: observed %0d expected %0d", s.tag, stallCycles, expStall);
    end
`endif
  endtask

  // Play the schedule and advance the counter model at each rising edge.
  task automatic runSteps();
    step_t s;
    while (stepQ.size() > 0) begin
      s = stepQ.pop_front();
      applyStimulus(s);
      checkOutput(s);
      @(negedge clk);
      if (s.rst) begin
        expInstr = 0;
        expStall = 0;
      end else begin
        if (s.retire) expInstr++;
        if (s.stall)  expStall++;
      end
    end
  endtask

  initial begin
    logic [6:0] opTable [6];
    opTable[0] = OP_LW; opTable[1] = OP_SW; opTable[2] = OP_R;
    opTable[3] = OP_I;  opTable[4] = OP_JAL; opTable[5] = OP_BEQ;

    reset = 1'b1; bus.Op = OP_R; bus.Zero = 1'b0; bus.MemReady = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state: FETCH selects with every strobe forced low despite MemReady.
    pushStep(OP_R, 1'b0, 1'b1, 1'b1, outWord(0,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,2'b00), 0, 0, "reset");
    runSteps();

    // Directed instructions with the latencies the controller must honour.
    buildInstr(OP_R, 0, 0, 1'b0);
    buildInstr(OP_LW, 0, 3, 1'b0);
    buildInstr(OP_SW, 0, 2, 1'b0);
    buildInstr(OP_BEQ, 0, 0, 1'b1);
    buildInstr(OP_BEQ, 0, 0, 1'b0);
    buildInstr(OP_I, 2, 0, 1'b0);
    buildInstr(OP_JAL, 1, 0, 1'b0);
    runSteps();

    // Random instruction mix with random fetch and memory stalls.
    for (int n = 0; n < 60; n++) begin
      buildInstr(opTable[$urandom_range(0, 5)], $urandom_range(0, 3), $urandom_range(0, 3), rndBit());
      runSteps();
    end

    // Reset arriving in MEMWRITE while the cache still stalls.
    pushStep(OP_SW, 1'b0, 1'b1, 1'b0, outWord(0,1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,2'b01), 0, 0, "abortFetch");
    pushStep(OP_SW, 1'b0, 1'b0, 1'b0, outWord(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b01), 0, 0, "abortDecode");
    pushStep(OP_SW, 1'b0, 1'b0, 1'b0, outWord(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,2'b01), 0, 0, "abortAddr");
    pushStep(OP_SW, 1'b0, 1'b0, 1'b1, outWord(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,2'b01), 0, 0, "abortReset");
    runSteps();
    buildInstr(OP_SW, 1, 1, 1'b0);
    runSteps();

    // Illegal opcode halts for good until reset, then fetching resumes.
    buildInstr(OP_BAD, 0, 0, 1'b0);
    pushStep(OP_BAD, 1'b1, 1'b1, 1'b1, outWord(1,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00), 0, 0, "haltReset");
    runSteps();
    buildInstr(OP_R, 0, 0, 1'b0);
    runSteps();

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
